// File: rtl/keypad_key_register_if.sv
// keypad_key_register_if: scanner <-> key register bundle.
// Scanner drives row/column sense; key register returns hold and key data.
interface keypad_key_register_if;
   logic [3:0] row_sel;
   logic [3:0] cols;
   logic       hold;
   logic       key_valid;
   logic [3:0] key;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   modport master (
      output row_sel, cols,
      input  hold, key_valid, key, digit_new, digit_old
   );

   modport slave (
      input  row_sel, cols,
      output hold, key_valid, key, digit_new, digit_old
   );
endinterface

// File: rtl/keypad_key_register.sv
// keypad_key_register: debounces one keypad press, emits hex code + 2-digit history.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module keypad_key_register #(
   parameter int DEBOUNCE_CYCLES = 50,
   parameter int REPEAT_CYCLES   = 200
) (
   input logic                   clk,
   input logic                   reset,
   keypad_key_register_if.slave  bus
);

   localparam int CNT_MAX =
      (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_row;
   logic [3:0]       r_col;
   logic             r_hold;
   logic             r_valid;
   logic [3:0]       r_key;
   logic [3:0]       r_dnew;
   logic [3:0]       r_dold;

   logic             w_cap;
   logic             w_bit;
   logic [3:0]       w_code;

   function automatic logic [1:0] oh_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      if (v[1]) idx = 2'd1;
      if (v[2]) idx = 2'd2;
      if (v[3]) idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [3:0] keymap(input logic [1:0] r,
                                         input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0:    k = 4'h1;
         4'h1:    k = 4'h2;
         4'h2:    k = 4'h3;
         4'h3:    k = 4'hA;
         4'h4:    k = 4'h4;
         4'h5:    k = 4'h5;
         4'h6:    k = 4'h6;
         4'h7:    k = 4'hB;
         4'h8:    k = 4'h7;
         4'h9:    k = 4'h8;
         4'hA:    k = 4'h9;
         4'hB:    k = 4'hC;
         4'hC:    k = 4'hE;
         4'hD:    k = 4'h0;
         4'hE:    k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Single-key capture qualifier, key lookup and "our key still down" sense.
   always_comb begin
      w_cap  = $onehot(bus.row_sel) && $onehot(bus.cols);
      w_code = keymap(oh_idx(bus.row_sel), oh_idx(bus.cols));
      w_bit  = (bus.row_sel == r_row) && |(bus.cols & r_col);
   end

   // Press/release debounce FSM with registered hold, strobe and digit history.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_hold  <= 1'b0;
         r_valid <= 1'b0;
         r_key   <= '0;
         r_dnew  <= '0;
         r_dold  <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cap) begin
                  r_row   <= bus.row_sel;
                  r_col   <= bus.cols;
                  r_key   <= w_code;
                  r_cnt   <= '0;
                  r_hold  <= 1'b1;
                  r_state <= S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (!w_bit) begin
                  r_cnt   <= '0;
                  r_hold  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_cnt == DEB_LAST) begin
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_dold  <= r_dnew;
                  r_dnew  <= r_key;
                  r_state <= S_PRESSED;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_PRESSED: begin
               if (!w_bit) begin
                  r_cnt   <= '0;
                  r_state <= S_RELEASE;
               end
`ifdef KEY_REPEAT_EN
               else if (r_cnt == REP_LAST) begin
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_dold  <= r_dnew;
                  r_dnew  <= r_key;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
`endif
            end
            S_RELEASE: begin
               if (w_bit) begin
                  r_cnt   <= '0;
                  r_state <= S_PRESSED;
               end else if (r_cnt == DEB_LAST) begin
                  r_cnt   <= '0;
                  r_hold  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_hold  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.hold      = r_hold;
   assign bus.key_valid = r_valid;
   assign bus.key       = r_key;
   assign bus.digit_new = r_dnew;
   assign bus.digit_old = r_dold;

endmodule

// File: tb/tb_keypad_key_register.sv
// tb_keypad_key_register: table vectors, corner sequences and random presses
// checked against an episode-level model of the key register.
module tb_keypad_key_register;

   localparam int D = 4;
   localparam int R = 6;
`ifdef KEY_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk;
   logic rst;

   keypad_key_register_if ifc ();

   keypad_key_register #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] exp_new = 4'h0;
   logic [3:0] exp_old = 4'h0;

   logic [3:0] km [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   typedef struct {
      logic [3:0] rs;
      logic [3:0] cs;
      bit         cap;
      logic [3:0] key;
   } vec_t;

   vec_t tv [20];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift(input logic [3:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         exp_old = exp_new;
         exp_new = code;
      end
   endtask

   function automatic bit valid_key(input logic [3:0] rs, input logic [3:0] cs);
      return $onehot(rs) && $onehot(cs);
   endfunction

   function automatic logic [3:0] model_code(input logic [3:0] rs,
                                             input logic [3:0] cs);
      return km[$clog2(rs) * 4 + $clog2(cs)];
   endfunction

   // strobes for a key held p edges from capture: first at edge D,
   // then every R edges while still held (repeat builds only)
   function automatic int model_strobes(input logic [3:0] rs,
                                        input logic [3:0] cs, input int p);
      if (!valid_key(rs, cs) || p < D + 1) return 0;
      if (REP) return 1 + (p - 1 - D) / R;
      return 1;
   endfunction

   task automatic episode(input logic [3:0] rs, input logic [3:0] cs,
                          input int p, input int l,
                          output int cap_hold, output int n_str,
                          output int first_i, output logic [3:0] k_seen,
                          output int end_hold);
      ifc.row_sel = rs;
      ifc.cols    = cs;
      n_str   = 0;
      first_i = -1;
      k_seen  = 4'h0;
      cap_hold = 0;
      for (int i = 0; i < p; i++) begin
         step();
         if (i == 0) cap_hold = int'(ifc.hold);
         if (ifc.key_valid) begin
            n_str++;
            if (first_i < 0) first_i = i;
            k_seen = ifc.key;
         end
      end
      ifc.cols = 4'b0000;
      for (int j = 0; j < l; j++) begin
         step();
         if (ifc.key_valid) n_str++;
      end
      end_hold = int'(ifc.hold);
   endtask

   task automatic model_ep(input string tag, input logic [3:0] rs,
                           input logic [3:0] cs, input int p, input int l);
      int ch, ns, fi, eh, ne;
      logic [3:0] ks, code;
      episode(rs, cs, p, l, ch, ns, fi, ks, eh);
      ne = model_strobes(rs, cs, p);
      chk({tag, " cap_hold"}, ch, int'(valid_key(rs, cs)));
      chk({tag, " strobes"}, ns, ne);
      if (ne > 0) begin
         code = model_code(rs, cs);
         chk({tag, " first_strobe"}, fi, D);
         chk({tag, " key"}, int'(ks), int'(code));
         shift(code, ne);
      end
      chk({tag, " digit_new"}, int'(ifc.digit_new), int'(exp_new));
      chk({tag, " digit_old"}, int'(ifc.digit_old), int'(exp_old));
      chk({tag, " end_hold"}, eh, 0);
   endtask

   initial begin
      int ch, ns, fi, eh, cnt;
      logic [3:0] ks, rs, cs;

      tv[0]  = '{4'b0001, 4'b0001, 1'b1, 4'h1};
      tv[1]  = '{4'b0001, 4'b0010, 1'b1, 4'h2};
      tv[2]  = '{4'b0001, 4'b0100, 1'b1, 4'h3};
      tv[3]  = '{4'b0001, 4'b1000, 1'b1, 4'hA};
      tv[4]  = '{4'b0010, 4'b0001, 1'b1, 4'h4};
      tv[5]  = '{4'b0010, 4'b0010, 1'b1, 4'h5};
      tv[6]  = '{4'b0010, 4'b0100, 1'b1, 4'h6};
      tv[7]  = '{4'b0010, 4'b1000, 1'b1, 4'hB};
      tv[8]  = '{4'b0100, 4'b0001, 1'b1, 4'h7};
      tv[9]  = '{4'b0100, 4'b0010, 1'b1, 4'h8};
      tv[10] = '{4'b0100, 4'b0100, 1'b1, 4'h9};
      tv[11] = '{4'b0100, 4'b1000, 1'b1, 4'hC};
      tv[12] = '{4'b1000, 4'b0001, 1'b1, 4'hE};
      tv[13] = '{4'b1000, 4'b0010, 1'b1, 4'h0};
      tv[14] = '{4'b1000, 4'b0100, 1'b1, 4'hF};
      tv[15] = '{4'b1000, 4'b1000, 1'b1, 4'hD};
      tv[16] = '{4'b0001, 4'b0011, 1'b0, 4'h0};
      tv[17] = '{4'b0011, 4'b0001, 1'b0, 4'h0};
      tv[18] = '{4'b0100, 4'b0000, 1'b0, 4'h0};
      tv[19] = '{4'b0000, 4'b0100, 1'b0, 4'h0};

      // reset held with a valid key present
      rst = 1'b1;
      ifc.row_sel = 4'b0001;
      ifc.cols    = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst hold", int'(ifc.hold), 0);
         chk("rst key_valid", int'(ifc.key_valid), 0);
         chk("rst digit_new", int'(ifc.digit_new), 0);
         chk("rst digit_old", int'(ifc.digit_old), 0);
      end
      chk("rst key", int'(ifc.key), 0);
      rst = 1'b0;
      model_ep("post_rst", 4'b0001, 4'b0010, D + 2, D + 2);

      // table vectors: keymap and rejection
      foreach (tv[n]) begin
         episode(tv[n].rs, tv[n].cs, D + 2, D + 2, ch, ns, fi, ks, eh);
         chk($sformatf("tv%0d cap_hold", n), ch, int'(tv[n].cap));
         chk($sformatf("tv%0d strobes", n), ns, int'(tv[n].cap));
         if (tv[n].cap) begin
            chk($sformatf("tv%0d key", n), int'(ks), int'(tv[n].key));
            shift(tv[n].key, 1);
         end
         chk($sformatf("tv%0d digit_new", n), int'(ifc.digit_new), int'(exp_new));
         chk($sformatf("tv%0d end_hold", n), eh, 0);
      end

      // bounce in debounce window: two cycles high then gone
      model_ep("bounce", 4'b0010, 4'b0100, 2, 1);

      // release bounce on key 5
      ifc.row_sel = 4'b0010;
      ifc.cols    = 4'b0010;
      cnt = 0;
      for (int i = 0; i <= D; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      ifc.cols = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("relb hold_in_release", int'(ifc.hold), 1);
      ifc.cols = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      ifc.cols = 4'b0000;
      for (int i = 0; i < D; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("relb hold_before_idle", int'(ifc.hold), 1);
      step();
      chk("relb hold_idle", int'(ifc.hold), 0);
      chk("relb strobes", cnt, 1);
      shift(4'h5, 1);
      chk("relb digit_new", int'(ifc.digit_new), int'(exp_new));
      chk("relb digit_old", int'(ifc.digit_old), int'(exp_old));

      // second key joins while F is held
      ifc.row_sel = 4'b1000;
      ifc.cols    = 4'b0100;
      cnt = 0;
      for (int i = 0; i <= D; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      ifc.cols = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("multi hold", int'(ifc.hold), 1);
      ifc.cols = 4'b0000;
      for (int i = 0; i <= D; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("multi strobes", cnt, 1);
      chk("multi key", int'(ifc.key), 4'hF);
      shift(4'hF, 1);
      chk("multi digit_new", int'(ifc.digit_new), int'(exp_new));
      chk("multi digit_old", int'(ifc.digit_old), int'(exp_old));

      // new key arriving on the release->idle edge waits a cycle
      ifc.row_sel = 4'b0001;
      ifc.cols    = 4'b0001;
      for (int i = 0; i <= D; i++) step();
      shift(4'h1, 1);
      ifc.cols = 4'b0000;
      for (int i = 0; i < D; i++) step();
      chk("simul hold_release", int'(ifc.hold), 1);
      ifc.cols = 4'b0010;
      step();
      chk("simul hold_idle", int'(ifc.hold), 0);
      step();
      chk("simul hold_capture", int'(ifc.hold), 1);
      cnt = 0;
      for (int i = 0; i < D; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("simul strobe_at_D", int'(ifc.key_valid), 1);
      chk("simul strobes", cnt, 1);
      chk("simul key", int'(ifc.key), 4'h2);
      shift(4'h2, 1);
      ifc.cols = 4'b0000;
      for (int i = 0; i <= D; i++) step();
      chk("simul digit_new", int'(ifc.digit_new), int'(exp_new));
      chk("simul digit_old", int'(ifc.digit_old), int'(exp_old));

      // reset while debouncing at cnt=2
      ifc.row_sel = 4'b0010;
      ifc.cols    = 4'b0100;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst hold", int'(ifc.hold), 0);
      chk("mrst key_valid", int'(ifc.key_valid), 0);
      chk("mrst key", int'(ifc.key), 0);
      chk("mrst digit_new", int'(ifc.digit_new), 0);
      chk("mrst digit_old", int'(ifc.digit_old), 0);
      exp_new = 4'h0;
      exp_old = 4'h0;
      ifc.cols = 4'b0000;
      cnt = 0;
      for (int i = 0; i < D + 2; i++) begin
         step();
         if (ifc.key_valid) cnt++;
      end
      chk("mrst strobes", cnt, 0);

      // random press episodes against the model
      for (int n = 0; n < 40; n++) begin
         rs = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) rs = 4'($urandom_range(0, 15));
         cs = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) cs = 4'($urandom_range(0, 15));
         model_ep($sformatf("rnd%0d", n), rs, cs,
                  $urandom_range(1, REP ? 22 : 12),
                  $urandom_range(D + 1, D + 3));
      end

      // long hold on key 9: repeats only in repeat builds
      model_ep("hold9", 4'b0100, 4'b0100, D + 1 + 20, D + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
